// File: rtl/arcade_input_mapper.sv
// Maps PS/2 key events and joystick bits onto active-low cabinet buttons through a loadable key table.
// Also provides coin pulse stretching and a shared autofire phase.
module arcade_input_mapper #(
    parameter int NUM_BTN  = 8,
    parameter int NUM_KEYS = 16,
    parameter int COIN_MIN = 250000,
    parameter int AF_HALF  = 625000
) (
    input  logic                        clk_25,
    input  logic                        RESET_L,
    input  logic [10:0]                 ps2_key,
    input  logic [15:0]                 joy,
    input  logic                        map_we,
    input  logic [$clog2(NUM_KEYS)-1:0] map_idx,
    input  logic [8:0]                  map_code,
    input  logic                        map_xdc,
    input  logic [3:0]                  map_btn,
    input  logic [NUM_BTN*5-1:0]        joy_sel,
    input  logic [NUM_BTN-1:0]          coin_mask,
    input  logic [NUM_BTN-1:0]          af_mask,
    output logic [NUM_BTN-1:0]          btn_l,
    output logic                        busy,
    output logic                        ovf
);

    // state   | meaning
    // IDLE    | waiting for a pending key event
    // SCAN    | walking the key table, one entry per cycle
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam int IDX_W  = $clog2(NUM_KEYS);
    localparam int COIN_W = $clog2(COIN_MIN + 1);
    localparam int AF_W   = $clog2(AF_HALF + 1);

    logic             tog_q;
    logic             slot_full;
    logic             slot_pr;
    logic [8:0]       slot_code;
    logic             wk_pr;
    logic [8:0]       wk_code;
    logic [0:0]       state;
    logic [IDX_W-1:0] scan_idx;
    logic             ovf_q;

    logic [NUM_KEYS-1:0] tab_v;
    logic [NUM_KEYS-1:0] tab_xdc;
    logic [8:0]          tab_code [NUM_KEYS];
    logic [3:0]          tab_btn  [NUM_KEYS];

    logic [NUM_BTN-1:0] key_state;
    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] raw_q;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] active;
    logic [NUM_BTN-1:0] btn_q;
    logic [NUM_BTN-1:0] coin_en;
    logic [NUM_BTN-1:0] af_en;
    logic [COIN_W-1:0]  coin_cnt [NUM_BTN];
    logic [AF_W-1:0]    af_cnt;
    logic               af_ph;
    logic               af_rise;
    logic               af_eff;

    logic ev;
    logic drain;
    logic accept;
    logic e_match;

    always_comb begin
        ev      = ps2_key[10] ^ tog_q;
        drain   = (state == ST_IDLE) && slot_full;
        // the slot frees in the same cycle it drains, so a coincident event still fits
        accept  = ev && (!slot_full || drain);
        e_match = tab_v[scan_idx]
                  && (tab_code[scan_idx][7:0] == wk_code[7:0])
                  && ((tab_code[scan_idx][8] == wk_code[8]) || tab_xdc[scan_idx]);
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                tab_v[k]    <= 1'b0;
                tab_xdc[k]  <= 1'b0;
                tab_code[k] <= 9'd0;
                tab_btn[k]  <= 4'd0;
            end
        end else if (map_we) begin
            tab_v[map_idx]    <= 1'b1;
            tab_xdc[map_idx]  <= map_xdc;
            tab_code[map_idx] <= map_code;
            tab_btn[map_idx]  <= map_btn;
        end
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            tog_q     <= ps2_key[10];
            slot_full <= 1'b0;
            slot_pr   <= 1'b0;
            slot_code <= 9'd0;
            wk_pr     <= 1'b0;
            wk_code   <= 9'd0;
            state     <= ST_IDLE;
            scan_idx  <= '0;
            ovf_q     <= 1'b0;
            key_state <= '0;
        end else begin
            tog_q <= ps2_key[10];
            if (accept) begin
                slot_full <= 1'b1;
                slot_pr   <= ps2_key[9];
                slot_code <= ps2_key[8:0];
            end else if (drain) begin
                slot_full <= 1'b0;
            end
            if (ev && !accept)
                ovf_q <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (slot_full) begin
                        wk_pr    <= slot_pr;
                        wk_code  <= slot_code;
                        scan_idx <= '0;
                        state    <= ST_SCAN;
                    end
                end
                default: begin
                    // later entries overwrite earlier ones, so the highest index wins
                    for (int i = 0; i < NUM_BTN; i++) begin
                        if (e_match && (tab_btn[scan_idx] == 4'(i)))
                            key_state[i] <= wk_pr;
                    end
                    if (scan_idx == IDX_W'(NUM_KEYS - 1))
                        state <= ST_IDLE;
                    else
                        scan_idx <= scan_idx + IDX_W'(1);
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++)
            raw[i] = key_state[i] | (joy_sel[5*i+4] & joy[joy_sel[5*i +: 4]]);
        rise    = raw & ~raw_q;
        coin_en = coin_mask;
        af_en   = af_mask & ~coin_mask;
        af_rise = |(rise & af_en);
        af_eff  = af_rise | af_ph;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (coin_en[i])
                active[i] = raw[i] | (coin_cnt[i] != '0);
            else if (af_en[i])
                active[i] = raw[i] & af_eff;
            else
                active[i] = raw[i];
        end
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            raw_q  <= '0;
            btn_q  <= '1;
            af_cnt <= '0;
            af_ph  <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++)
                coin_cnt[i] <= '0;
        end else begin
            raw_q <= raw;
            btn_q <= ~active;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (coin_en[i] && rise[i])
                    coin_cnt[i] <= COIN_W'(COIN_MIN - 1);
                else if (coin_cnt[i] != '0)
                    coin_cnt[i] <= coin_cnt[i] - COIN_W'(1);
            end
            if (af_rise) begin
                af_cnt <= '0;
                af_ph  <= 1'b1;
            end else if (af_cnt == AF_W'(AF_HALF - 1)) begin
                af_cnt <= '0;
                af_ph  <= ~af_ph;
            end else begin
                af_cnt <= af_cnt + AF_W'(1);
            end
        end
    end

    assign btn_l = btn_q;
    assign busy  = (state == ST_SCAN);
    assign ovf   = ovf_q;

endmodule
